// File: rtl/mc_pkg.sv
// Shared types and decode constants for the multicycle controller.
package mc_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned STATE_W = 3;
    localparam int unsigned OPC_W   = 6;
    localparam int unsigned CNT_W   = 32;

    // Controller states; encodings are visible on the debug port.
    typedef enum logic [STATE_W-1:0] {
        S_IDLE = 3'd0,
        S_IF   = 3'd1,
        S_ID   = 3'd2,
        S_EX   = 3'd3,
        S_MEM  = 3'd4,
        S_WB   = 3'd5,
        S_HALT = 3'd6
    } state_t;

    // Primary opcodes, instr[31:26].
    localparam logic [OPC_W-1:0] OP_ARI = 6'h00;
    localparam logic [OPC_W-1:0] OP_LUI = 6'h05;
    localparam logic [OPC_W-1:0] OP_MEM = 6'h0A;
    localparam logic [OPC_W-1:0] OP_BNE = 6'h17;

    // Sub-opcodes below the primary opcode.
    localparam logic [10:0] SUB_ADD_W   = 11'h020;  // instr[25:15]
    localparam logic [3:0]  SUB_ADDI_W  = 4'hA;     // instr[25:22]
    localparam logic        SUB_LU12I_W = 1'b0;     // instr[25]
    localparam logic [3:0]  SUB_LD_W    = 4'h2;     // instr[25:22]
    localparam logic [3:0]  SUB_ST_W    = 4'h6;     // instr[25:22]

    // Per-cycle datapath control strobes produced by the FSM.
    typedef struct packed {
        logic mem_req;
        logic mem_we;
        logic ir_we;
        logic ab_we;
        logic alu_out_we;
        logic mdr_we;
        logic rf_we;
        logic pc_we;
        logic pc_sel;
        logic retire;
    } ctl_t;

    // Primary opcode field of an instruction word.
    function automatic logic [OPC_W-1:0] opcode(input logic [XLEN-1:0] w);
        return w[31:26];
    endfunction

endpackage

// File: rtl/mc_classify.sv
// Combinational instruction classifier for the supported subset.
module mc_classify
    import mc_pkg::*;
(
    input  logic [XLEN-1:0] instr,
    output logic            legal,
    output logic            is_ld,
    output logic            is_st,
    output logic            is_br,
    output logic            is_wb
);

    logic [OPC_W-1:0] op;
    logic             is_add;
    logic             is_addi;
    logic             is_lui;
    logic             unused_low;

    assign op         = opcode(instr);
    // Register/immediate fields play no part in sequencing.
    assign unused_low = ^instr[14:0];

    // Match each supported encoding and derive the class flags.
    always_comb begin
        is_add  = (op == OP_ARI) && (instr[25:15] == SUB_ADD_W);
        is_addi = (op == OP_ARI) && (instr[25:22] == SUB_ADDI_W);
        is_lui  = (op == OP_LUI) && (instr[25]    == SUB_LU12I_W);
        is_ld   = (op == OP_MEM) && (instr[25:22] == SUB_LD_W);
        is_st   = (op == OP_MEM) && (instr[25:22] == SUB_ST_W);
        is_br   = (op == OP_BNE);
        is_wb   = is_add || is_addi || is_lui || is_ld;
        legal   = is_wb || is_st || is_br;
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle CPU control FSM with retire counter and sticky illegal flag.
module mc_ctrl
    import mc_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic [XLEN-1:0]    instr,
    input  logic               br_taken,
    input  logic               mem_ack,
    output logic               mem_req,
    output logic               mem_we,
    output logic               ir_we,
    output logic               ab_we,
    output logic               alu_out_we,
    output logic               mdr_we,
    output logic               rf_we,
    output logic               pc_we,
    output logic               pc_sel,
    output logic [STATE_W-1:0] state_o,
    output logic               illegal,
    output logic               retire,
    output logic [CNT_W-1:0]   retired_cnt
);

    state_t state;
    state_t state_next;
    ctl_t   ctl;
    logic   legal;
    logic   is_ld;
    logic   is_st;
    logic   is_br;
    logic   is_wb;
    logic   set_illegal;
    logic   retire_now;

    mc_classify u_classify (
        .instr (instr),
        .legal (legal),
        .is_ld (is_ld),
        .is_st (is_st),
        .is_br (is_br),
        .is_wb (is_wb)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Sticky illegal-instruction flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal <= 1'b0;
        end else if (set_illegal) begin
            illegal <= 1'b1;
        end
    end

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            retired_cnt <= '0;
        end else if (ctl.retire) begin
            retired_cnt <= retired_cnt + CNT_W'(1);
        end
    end

    // Next-state and control strobes; PC only moves in the retiring cycle.
    always_comb begin
        state_next  = state;
        ctl         = '0;
        set_illegal = 1'b0;
        retire_now  = 1'b0;

        case (state)
            S_IDLE: begin
                if (run) begin
                    state_next = S_IF;
                end
            end
            S_IF: begin
                ctl.mem_req = 1'b1;
                if (mem_ack) begin
                    ctl.ir_we  = 1'b1;
                    state_next = S_ID;
                end
            end
            S_ID: begin
                ctl.ab_we = 1'b1;
                if (legal) begin
                    state_next = S_EX;
                end else begin
                    state_next  = S_HALT;
                    set_illegal = 1'b1;
                end
            end
            S_EX: begin
                ctl.alu_out_we = 1'b1;
                if (is_br) begin
                    retire_now = 1'b1;
                    ctl.pc_sel = br_taken;
                end else if (is_ld || is_st) begin
                    state_next = S_MEM;
                end else if (is_wb) begin
                    state_next = S_WB;
                end else begin
                    // Instruction word changed after decode; park safely.
                    state_next = S_HALT;
                end
            end
            S_MEM: begin
                ctl.mem_req = 1'b1;
                ctl.mem_we  = is_st;
                if (mem_ack) begin
                    if (is_ld) begin
                        ctl.mdr_we = 1'b1;
                        state_next = S_WB;
                    end else begin
                        retire_now = 1'b1;
                    end
                end
            end
            S_WB: begin
                ctl.rf_we  = 1'b1;
                retire_now = 1'b1;
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // run is only consulted at the instruction boundary.
        if (retire_now) begin
            ctl.pc_we  = 1'b1;
            ctl.retire = 1'b1;
            state_next = run ? S_IF : S_IDLE;
        end

        // Reset silences every strobe in the same cycle.
        if (rst) begin
            ctl         = '0;
            set_illegal = 1'b0;
            state_next  = S_IDLE;
        end
    end

    assign mem_req    = ctl.mem_req;
    assign mem_we     = ctl.mem_we;
    assign ir_we      = ctl.ir_we;
    assign ab_we      = ctl.ab_we;
    assign alu_out_we = ctl.alu_out_we;
    assign mdr_we     = ctl.mdr_we;
    assign rf_we      = ctl.rf_we;
    assign pc_we      = ctl.pc_we;
    assign pc_sel     = ctl.pc_sel;
    assign retire     = ctl.retire;
    assign state_o    = STATE_W'(state);

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-cycle reference model plus directed traces.
module tb_mc_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        br_taken = 1'b0;
    logic        mem_ack = 1'b0;
    logic        mem_req, mem_we, ir_we, ab_we, alu_out_we, mdr_we;
    logic        rf_we, pc_we, pc_sel, illegal, retire;
    logic [2:0]  state_o;
    logic [31:0] retired_cnt;
    logic [9:0]  dut_ctl;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] I_ADD = 32'h00101CA5;
    localparam logic [31:0] I_LD  = 32'h28802064;
    localparam logic [31:0] I_ST  = 32'h29800000;
    localparam logic [31:0] I_BNE = 32'h5C000000;
    localparam logic [31:0] I_BAD = 32'hFFFFFFFF;

    // Bit positions inside dut_ctl.
    localparam int B_MEM_REQ = 9;
    localparam int B_MEM_WE  = 8;
    localparam int B_IR      = 7;
    localparam int B_AB      = 6;
    localparam int B_ALU     = 5;
    localparam int B_MDR     = 4;
    localparam int B_RF      = 3;
    localparam int B_PCWE    = 2;
    localparam int B_PCSEL   = 1;
    localparam int B_RET     = 0;

    // Instruction classes of the model.
    localparam int C_ALU = 0;
    localparam int C_LD  = 1;
    localparam int C_ST  = 2;
    localparam int C_BR  = 3;
    localparam int C_ILL = 4;

    mc_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .instr       (instr),
        .br_taken    (br_taken),
        .mem_ack     (mem_ack),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .ir_we       (ir_we),
        .ab_we       (ab_we),
        .alu_out_we  (alu_out_we),
        .mdr_we      (mdr_we),
        .rf_we       (rf_we),
        .pc_we       (pc_we),
        .pc_sel      (pc_sel),
        .state_o     (state_o),
        .illegal     (illegal),
        .retire      (retire),
        .retired_cnt (retired_cnt)
    );

    always #5 clk = ~clk;

    assign dut_ctl = {mem_req, mem_we, ir_we, ab_we, alu_out_we,
                      mdr_we, rf_we, pc_we, pc_sel, retire};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: actual %0h required %0h", name, $time, act, exp);
        end
    endtask

    // Mask/match table of the supported encodings.
    function automatic int decode(input logic [31:0] w);
        if ((w & 32'hFFFF8000) == 32'h00100000) return C_ALU;
        if ((w & 32'hFFC00000) == 32'h02800000) return C_ALU;
        if ((w & 32'hFE000000) == 32'h14000000) return C_ALU;
        if ((w & 32'hFFC00000) == 32'h28800000) return C_LD;
        if ((w & 32'hFFC00000) == 32'h29800000) return C_ST;
        if ((w & 32'hFC000000) == 32'h5C000000) return C_BR;
        return C_ILL;
    endfunction

    // Number of phases each class walks through; the last one retires.
    function automatic int route_len(input int c);
        case (c)
            C_ALU:   return 4;
            C_LD:    return 5;
            C_ST:    return 4;
            C_BR:    return 3;
            default: return 2;
        endcase
    endfunction

    // Phase (state number) at step p of the class route.
    function automatic int route_at(input int c, input int p);
        case (p)
            0:       return 1;
            1:       return 2;
            2:       return 3;
            3:       return (c == C_LD || c == C_ST) ? 4 : 5;
            default: return 5;
        endcase
    endfunction

    // Model: mode 0 idle, 1 executing at route step m_pos, 2 halted.
    int          m_mode = 0;
    int          m_pos  = 0;
    logic        m_ill  = 1'b0;
    logic [31:0] m_cnt  = 32'h0;

    // Compare DUT against model mid-cycle, then advance the model for the coming edge.
    always @(negedge clk) begin : cmp
        int         c;
        int         ph;
        bit         waiting;
        bit         adv;
        bit         last;
        logic [9:0] e;
        logic [2:0] es;

        c       = decode(instr);
        ph      = 0;
        waiting = 1'b0;
        adv     = 1'b0;
        last    = 1'b0;
        e       = '0;
        if (m_mode == 1) begin
            ph      = route_at(c, m_pos);
            waiting = (ph == 1) || (ph == 4);
            adv     = !waiting || mem_ack;
            last    = (m_pos >= 2) && (m_pos == route_len(c) - 1);
        end
        es = (m_mode == 0) ? 3'd0 : (m_mode == 2) ? 3'd6 : 3'(ph);

        if (!rst && m_mode == 1) begin
            e[B_MEM_REQ] = waiting;
            e[B_MEM_WE]  = (ph == 4) && (c == C_ST);
            e[B_IR]      = (ph == 1) && mem_ack;
            e[B_AB]      = (ph == 2);
            e[B_ALU]     = (ph == 3);
            e[B_MDR]     = (ph == 4) && mem_ack && (c == C_LD);
            e[B_RF]      = (ph == 5);
            e[B_RET]     = last && adv;
            e[B_PCWE]    = last && adv;
            e[B_PCSEL]   = last && adv && (c == C_BR) && br_taken;
        end

        check("model_ctl",   64'(dut_ctl),     64'(e));
        check("model_state", 64'(state_o),     64'(es));
        check("model_ill",   64'(illegal),     64'(m_ill));
        check("model_cnt",   64'(retired_cnt), 64'(m_cnt));

        if (rst) begin
            m_mode = 0;
            m_pos  = 0;
            m_ill  = 1'b0;
            m_cnt  = 32'h0;
        end else if (m_mode == 0) begin
            if (run) begin
                m_mode = 1;
                m_pos  = 0;
            end
        end else if (m_mode == 1) begin
            if (m_pos == 1 && c == C_ILL) begin
                m_mode = 2;
                m_ill  = 1'b1;
            end else if (adv) begin
                if (last) begin
                    m_cnt  = m_cnt + 32'd1;
                    m_pos  = 0;
                    m_mode = run ? 1 : 0;
                end else begin
                    m_pos = m_pos + 1;
                end
            end
        end
    end

    // Directed-trace recording, index = cycles since IF entry.
    logic [2:0]  r_st  [16];
    logic [9:0]  r_ctl [16];
    logic        r_ill [16];
    logic [31:0] r_cnt [16];

    task automatic cyc(input int k, input logic [31:0] ins, input logic ack,
                       input logic brt, input logic run_v, input logic rst_v);
        @(posedge clk);
        #1;
        instr    = ins;
        mem_ack  = ack;
        br_taken = brt;
        run      = run_v;
        rst      = rst_v;
        @(negedge clk);
        r_st[k]  = state_o;
        r_ctl[k] = dut_ctl;
        r_ill[k] = illegal;
        r_cnt[k] = retired_cnt;
    endtask

    // Leaves the DUT in IDLE with rst low, just after a rising edge.
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst      = 1'b1;
        run      = 1'b0;
        mem_ack  = 1'b0;
        br_taken = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [15:0] col(input int b, input int n);
        logic [15:0] v = '0;
        for (int k = 0; k < n; k++) v[k] = r_ctl[k][b];
        return v;
    endfunction

    function automatic logic [31:0] states(input int n);
        logic [31:0] v = '0;
        for (int k = 0; k < n; k++) v = {v[27:0], 1'b0, r_st[k]};
        return v;
    endfunction

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        logic [3:0] st_acks;
        logic [6:0] acks;

        // Reset state.
        do_reset();
        @(negedge clk);
        check("reset_state", 64'(state_o), 64'd0);
        check("reset_cnt",   64'(retired_cnt), 64'd0);
        check("reset_ctl",   64'(dut_ctl), 64'd0);

        // add.w; br_taken held high must not steer the PC.
        do_reset();
        instr = I_ADD;
        run   = 1'b1;
        for (int k = 0; k < 5; k++) cyc(k, I_ADD, 1'b1, 1'b1, 1'b1, 1'b0);
        check("add_states", 64'(states(4)), 64'h1235);
        check("add_ir_we",  64'(col(B_IR, 4)), 64'b0001);
        check("add_ab_we",  64'(col(B_AB, 4)), 64'b0010);
        check("add_alu_we", 64'(col(B_ALU, 4)), 64'b0100);
        check("add_rf_we",  64'(col(B_RF, 4)), 64'b1000);
        check("add_pc_we",  64'(col(B_PCWE, 4)), 64'b1000);
        check("add_pc_sel", 64'(col(B_PCSEL, 4)), 64'b0000);
        check("add_retire", 64'(col(B_RET, 4)), 64'b1000);
        check("add_cnt_pre", 64'(r_cnt[3]), 64'd0);
        check("add_cnt",    64'(r_cnt[4]), 64'd1);
        check("add_next_if", 64'(r_st[4]), 64'd1);

        // ld.w.
        do_reset();
        instr = I_LD;
        run   = 1'b1;
        for (int k = 0; k < 5; k++) cyc(k, I_LD, 1'b1, 1'b0, 1'b1, 1'b0);
        check("ld_states",  64'(states(5)), 64'h12345);
        check("ld_mem_req", 64'(col(B_MEM_REQ, 5)), 64'b01001);
        check("ld_mem_we",  64'(col(B_MEM_WE, 5)), 64'b00000);
        check("ld_mdr_we",  64'(col(B_MDR, 5)), 64'b01000);
        check("ld_rf_we",   64'(col(B_RF, 5)), 64'b10000);
        check("ld_retire",  64'(col(B_RET, 5)), 64'b10000);

        // st.w with three MEM wait cycles.
        do_reset();
        instr = I_ST;
        run   = 1'b1;
        acks  = 7'b1000111;
        for (int k = 0; k < 7; k++) cyc(k, I_ST, acks[k], 1'b0, 1'b1, 1'b0);
        check("st_states",  64'(states(7)), 64'h1234444);
        check("st_mem_req", 64'(col(B_MEM_REQ, 7)), 64'b1111001);
        check("st_mem_we",  64'(col(B_MEM_WE, 7)), 64'b1111000);
        check("st_pc_we",   64'(col(B_PCWE, 7)), 64'b1000000);
        check("st_rf_we",   64'(col(B_RF, 7)), 64'b0000000);
        check("st_retire",  64'(col(B_RET, 7)), 64'b1000000);

        // bne taken, then not taken back to back.
        do_reset();
        instr   = I_BNE;
        run     = 1'b1;
        st_acks = 4'b0;
        for (int k = 0; k < 6; k++) cyc(k, I_BNE, 1'b1, (k != 5), 1'b1, 1'b0);
        check("bne_states", 64'(states(6)), 64'h123123);
        check("bne_retire", 64'(col(B_RET, 6)), 64'b100100);
        check("bne_pc_sel", 64'(col(B_PCSEL, 6)), 64'b000100);
        check("bne_cnt",    64'(r_cnt[5]), 64'd1);

        // Illegal instruction halts and sticks until reset.
        do_reset();
        instr = I_BAD;
        run   = 1'b1;
        for (int k = 0; k < 6; k++) cyc(k, I_BAD, 1'b1, 1'b1, 1'b1, 1'b0);
        check("ill_states",  64'(states(6)), 64'h126666);
        check("ill_flag_id", 64'(r_ill[1]), 64'd0);
        check("ill_flag",    64'(r_ill[5]), 64'd1);
        check("ill_pc_we",   64'(col(B_PCWE, 6)), 64'b000000);
        check("ill_cnt",     64'(r_cnt[5]), 64'd0);
        do_reset();
        cyc(0, I_BAD, 1'b1, 1'b0, 1'b0, 1'b0);
        check("ill_rst_state", 64'(r_st[0]), 64'd0);
        check("ill_rst_flag",  64'(r_ill[0]), 64'd0);

        // Reset while ld.w waits in MEM with mem_req asserted.
        do_reset();
        instr = I_ADD;
        run   = 1'b1;
        for (int k = 0; k < 4; k++) cyc(k, I_ADD, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(4, I_LD, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(5, I_LD, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(6, I_LD, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(7, I_LD, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(8, I_LD, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc(9, I_LD, 1'b1, 1'b0, 1'b0, 1'b0);
        check("rmem_state",   64'(r_st[7]), 64'd4);
        check("rmem_req",     64'(r_ctl[7][B_MEM_REQ]), 64'd1);
        check("rmem_cnt",     64'(r_cnt[7]), 64'd1);
        check("rmem_rst_ctl", 64'(r_ctl[8]), 64'd0);
        check("rmem_idle",    64'(r_st[9]), 64'd0);
        check("rmem_cnt0",    64'(r_cnt[9]), 64'd0);

        // run dropped during EX: add still retires, then IDLE.
        do_reset();
        instr = I_ADD;
        run   = 1'b1;
        for (int k = 0; k < 6; k++) cyc(k, I_ADD, 1'b1, 1'b0, (k < 2), 1'b0);
        check("stop_states", 64'(states(6)), 64'h123500);
        check("stop_retire", 64'(col(B_RET, 6)), 64'b001000);
        check("stop_cnt",    64'(r_cnt[5]), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
